// File: rtl/guvm_wb_pkg.sv
// ============================================================================
// guvm_wb_pkg : shared bus widths, responder states and lane-merge helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package guvm_wb_pkg;

  localparam int          WB_DW         = 128;
  localparam int          WB_SW         = 16;
  localparam logic [31:0] NOP_WORD_DFLT = 32'hF0081003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  // Keeps only the selected bytes of a 32-bit word; unselected bytes read as 0.
  function automatic logic [31:0] lane_merge(input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] merged;
    merged = '0;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = dat[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/guvm_inst_fifo.sv
// ============================================================================
// guvm_inst_fifo : 32-bit synchronous instruction queue, power-of-two depth
// Revision: 1.0
// ============================================================================
`default_nettype none

module guvm_inst_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/guvm_wb_responder.sv
// ============================================================================
// guvm_wb_responder : Wishbone classic slave feeding queued instructions to the
//                     core, capturing stores, with ack latency and error arm
// Revision: 1.0
// ============================================================================
`default_nettype none

module guvm_wb_responder
  import guvm_wb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          ACK_LAT    = 0,
  parameter logic [31:0] NOP_WORD   = NOP_WORD_DFLT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [31:0]      i_wb_adr,
  input  logic [WB_SW-1:0] i_wb_sel,
  input  logic [WB_DW-1:0] i_wb_dat,
  output logic [WB_DW-1:0] o_wb_dat,
  output logic             o_wb_ack,
  output logic             o_wb_err,
  input  logic [31:0]      i_inst,
  input  logic             i_inst_vld,
  output logic             o_inst_rdy,
  input  logic             i_err_inject,
  output logic [31:0]      o_wdata,
  output logic [31:0]      o_wdata_adr,
  output logic             o_wdata_vld,
  output logic [15:0]      o_underflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam bit          NO_WAIT = (ACK_LAT == 0);
  localparam logic [3:0]  LAT_M1  = NO_WAIT ? 4'd0 : 4'(ACK_LAT - 1);

  resp_state_t state;
  logic [3:0]  wait_cnt;
  logic        req_we;
  logic [31:0] req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        err_armed;

  logic        is_idle;
  logic        cur_we;
  logic [31:0] cur_adr;
  logic [3:0]  cur_sel;
  logic [31:0] cur_dat;
  logic        go_ack;
  logic        go_ok;
  logic        go_err;
  logic        rd_ok;
  logic        wr_ok;
  logic        q_empty_now;

  logic [31:0] fifo_head;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_bits;

  assign unused_bits = ^{i_wb_sel[15:4], i_wb_dat[127:32]};

  // With no wait state the request is answered on its own sampling edge, so
  // the live bus fields stand in for the not-yet-captured ones.
  assign is_idle = (state == IDLE);
  assign cur_we  = is_idle ? i_wb_we        : req_we;
  assign cur_adr = is_idle ? i_wb_adr       : req_adr;
  assign cur_sel = is_idle ? i_wb_sel[3:0]  : req_sel;
  assign cur_dat = is_idle ? i_wb_dat[31:0] : req_dat;

  assign go_ack = (is_idle && i_wb_cyc && i_wb_stb && NO_WAIT) ||
                  (state == WAIT && i_wb_cyc && wait_cnt == 4'd0);
  assign go_ok       = go_ack & ~err_armed;
  assign go_err      = go_ack &  err_armed;
  assign rd_ok       = go_ok & ~cur_we;
  assign wr_ok       = go_ok &  cur_we;
  assign q_empty_now = (fifo_count == '0);
  assign o_inst_rdy  = ~fifo_full;

  guvm_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_inst_vld),
    .pop   (rd_ok & ~fifo_empty),
    .wdata (i_inst),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      req_we      <= 1'b0;
      req_adr     <= '0;
      req_sel     <= '0;
      req_dat     <= '0;
      err_armed   <= 1'b0;
      o_wb_dat    <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      o_wdata     <= '0;
      o_wdata_adr <= '0;
      o_wdata_vld <= 1'b0;
      o_underflow <= '0;
    end else begin
      o_wb_ack    <= go_ok;
      o_wb_err    <= go_err;
      o_wdata_vld <= wr_ok;
      err_armed   <= go_err ? i_err_inject : (err_armed | i_err_inject);

      if (rd_ok) begin
        o_wb_dat <= {{3{NOP_WORD}}, q_empty_now ? NOP_WORD : fifo_head};
        if (q_empty_now) o_underflow <= o_underflow + 16'd1;
      end
      if (wr_ok) begin
        o_wdata     <= lane_merge(cur_dat, cur_sel);
        o_wdata_adr <= cur_adr;
      end

      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            req_we   <= i_wb_we;
            req_adr  <= i_wb_adr;
            req_sel  <= i_wb_sel[3:0];
            req_dat  <= i_wb_dat[31:0];
            wait_cnt <= LAT_M1;
            state    <= NO_WAIT ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!i_wb_cyc)              state    <= IDLE;
          else if (wait_cnt == 4'd0)  state    <= ACK;
          else                        wait_cnt <= wait_cnt - 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_guvm_wb_responder.sv
// ============================================================================
// tb_guvm_wb_responder : directed bench, one instance with ACK_LAT=0, one with 3
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_guvm_wb_responder;

  localparam logic [31:0] NOP = 32'hF0081003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst      [2];
  logic         cyc      [2];
  logic         stb      [2];
  logic         we       [2];
  logic [31:0]  adr      [2];
  logic [15:0]  sel      [2];
  logic [127:0] wbdat    [2];
  logic [31:0]  inst     [2];
  logic         inst_vld [2];
  logic         err_inj  [2];
  logic [127:0] rdat     [2];
  logic         ack      [2];
  logic         err      [2];
  logic         rdy      [2];
  logic [31:0]  wdata    [2];
  logic [31:0]  wadr     [2];
  logic         wvld     [2];
  logic [15:0]  uflow    [2];

  int errors = 0;
  int checks = 0;

  guvm_wb_responder #(.FIFO_DEPTH(8), .ACK_LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
    .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_dat(wbdat[0]), .o_wb_dat(rdat[0]),
    .o_wb_ack(ack[0]), .o_wb_err(err[0]), .i_inst(inst[0]), .i_inst_vld(inst_vld[0]),
    .o_inst_rdy(rdy[0]), .i_err_inject(err_inj[0]), .o_wdata(wdata[0]),
    .o_wdata_adr(wadr[0]), .o_wdata_vld(wvld[0]), .o_underflow(uflow[0])
  );

  guvm_wb_responder #(.FIFO_DEPTH(8), .ACK_LAT(3)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
    .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_dat(wbdat[1]), .o_wb_dat(rdat[1]),
    .o_wb_ack(ack[1]), .o_wb_err(err[1]), .i_inst(inst[1]), .i_inst_vld(inst_vld[1]),
    .o_inst_rdy(rdy[1]), .i_err_inject(err_inj[1]), .o_wdata(wdata[1]),
    .o_wdata_adr(wadr[1]), .o_wdata_vld(wvld[1]), .o_underflow(uflow[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] w);
    @(negedge clk);
    inst[d]     = w;
    inst_vld[d] = 1'b1;
    @(negedge clk);
    inst_vld[d] = 1'b0;
  endtask

  task automatic pulse_inject(input int d);
    @(negedge clk);
    err_inj[d] = 1'b1;
    @(negedge clk);
    err_inj[d] = 1'b0;
  endtask

  // lat counts edges from the sampling edge to the edge that sees ack/err high.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [15:0] s,
                      input logic [127:0] dt, output int lat, output logic [127:0] rd,
                      output logic ak, output logic er, output logic vl, output logic tail);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wbdat[d] = dt;
    lat = -1; rd = '0; ak = 1'b0; er = 1'b0; vl = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = k; ak = ack[d]; er = err[d]; vl = wvld[d]; rd = rdat[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(negedge clk);
    tail = ack[d] | err[d] | wvld[d];
  endtask

  int           lat;
  logic [127:0] rd;
  logic         ak, er, vl, tail, seen;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = '0;
      sel[d] = '0; wbdat[d] = '0; inst[d] = '0; inst_vld[d] = 1'b0; err_inj[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack",   128'(ack[0]),   128'(0));
    chk("rst_err",   128'(err[0]),   128'(0));
    chk("rst_rdat",  rdat[0],        128'(0));
    chk("rst_rdy",   128'(rdy[0]),   128'(1));
    chk("rst_uflow", 128'(uflow[0]), 128'(0));
    chk("rst_wvld",  128'(wvld[0]),  128'(0));
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Single queued read, no wait states
    push(0, 32'hE3A01005);
    xfer(0, 1'b0, 32'h0, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("rd1_lat",  128'(lat), 128'(1));
    chk("rd1_ack",  128'(ak),  128'(1));
    chk("rd1_err",  128'(er),  128'(0));
    chk("rd1_data", rd, {NOP, NOP, NOP, 32'hE3A01005});
    chk("rd1_tail", 128'(tail), 128'(0));

    // Empty-queue read, then a refilled read
    xfer(0, 1'b0, 32'h4, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("emp_lane0", 128'(rd[31:0]), 128'(NOP));
    chk("emp_uflow", 128'(uflow[0]), 128'(1));
    push(0, 32'h12345678);
    xfer(0, 1'b0, 32'h8, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("refill_data",  rd, {NOP, NOP, NOP, 32'h12345678});
    chk("refill_uflow", 128'(uflow[0]), 128'(1));

    // Store capture with partial byte selects
    xfer(0, 1'b1, 32'h100, 16'h0003, {96'h0, 32'hDEADBEEF}, lat, rd, ak, er, vl, tail);
    chk("wr1_ack",   128'(ak),       128'(1));
    chk("wr1_vld",   128'(vl),       128'(1));
    chk("wr1_data",  128'(wdata[0]), 128'(32'h0000BEEF));
    chk("wr1_adr",   128'(wadr[0]),  128'(32'h100));
    chk("wr1_tail",  128'(tail),     128'(0));
    xfer(0, 1'b1, 32'h204, 16'hFF0A, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h11223344},
         lat, rd, ak, er, vl, tail);
    chk("wr2_data",  128'(wdata[0]), 128'(32'h11003300));
    chk("wr2_adr",   128'(wadr[0]),  128'(32'h204));

    // Error injection: errored read keeps the entry, next read gets it
    push(0, 32'hAAAA0001);
    pulse_inject(0);
    xfer(0, 1'b0, 32'h10, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("einj_err",  128'(er),   128'(1));
    chk("einj_ack",  128'(ak),   128'(0));
    chk("einj_tail", 128'(tail), 128'(0));
    xfer(0, 1'b0, 32'h14, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("epost_ack",   128'(ak),       128'(1));
    chk("epost_err",   128'(er),       128'(0));
    chk("epost_data",  128'(rd[31:0]), 128'(32'hAAAA0001));
    chk("epost_uflow", 128'(uflow[0]), 128'(1));
    pulse_inject(0);
    xfer(0, 1'b1, 32'h300, 16'h000F, {96'h0, 32'hCAFEF00D}, lat, rd, ak, er, vl, tail);
    chk("ewr_err", 128'(er), 128'(1));
    chk("ewr_vld", 128'(vl), 128'(0));

    // ACK_LAT=3: fill, overflow attempt, interleave across pointer wrap
    for (int i = 0; i < 8; i++) push(1, 32'hC0DE0000 + 32'(i));
    chk("full_rdy", 128'(rdy[1]), 128'(0));
    push(1, 32'hBAD0BAD0);
    for (int i = 0; i < 10; i++) begin
      xfer(1, 1'b0, 32'(i * 16), 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
      chk("lat3_lat",  128'(lat), 128'(4));
      chk("lat3_data", rd, {NOP, NOP, NOP, 32'hC0DE0000 + 32'(i)});
      if (i == 0) chk("lat3_rdy", 128'(rdy[1]), 128'(1));
      if (i < 2) push(1, 32'hC0DE0008 + 32'(i));
    end
    chk("lat3_uflow", 128'(uflow[1]), 128'(0));

    // Reset in the middle of a WAIT with entries queued
    push(1, 32'h1); push(1, 32'h2); push(1, 32'h3);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("mrst_ack", 128'(ack[1]), 128'(0));
    chk("mrst_rdy", 128'(rdy[1]), 128'(1));
    @(negedge clk);
    rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | ack[1] | err[1];
    end
    chk("mrst_noack", 128'(seen), 128'(0));
    xfer(1, 1'b0, 32'h40, 16'hFFFF, '0, lat, rd, ak, er, vl, tail);
    chk("mrst_lat",   128'(lat),       128'(4));
    chk("mrst_data",  128'(rd[31:0]),  128'(NOP));
    chk("mrst_uflow", 128'(uflow[1]),  128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
